// File: rtl/alu_pkg.sv
// alu_pkg: ALU op encodings, compare field positions and the pipeline micro-op record
package alu_pkg;
  localparam logic [2:0] ALU_ADD_SUB = 3'd0;
  localparam logic [2:0] ALU_SLL = 3'd1;
  localparam logic [2:0] ALU_SLT = 3'd2;
  localparam logic [2:0] ALU_SLTU = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SRL_SRA = 3'd5;
  localparam logic [2:0] ALU_OR = 3'd6;
  localparam logic [2:0] ALU_AND_CLR = 3'd7;
  localparam int CMP_LESS = 2;
  localparam int CMP_UNSIGNED = 1;
  localparam int CMP_NEGATE = 0;
  localparam int UOP_XLEN = 64;
  localparam int UOP_VA = 39;
  localparam int UOP_ROB = 6;
  localparam int UOP_PRD = 6;
  typedef struct packed {
    logic [UOP_XLEN-1:0] result;
    logic cmp;
    logic is_jump;
    logic is_branch;
    logic [UOP_VA-1:0] pc;
    logic [UOP_VA-1:0] next_pc;
    logic [UOP_ROB-1:0] rob;
    logic [UOP_PRD-1:0] prd;
  } alu_uop_t;
endpackage

// File: rtl/alu_exec_comb.sv
// alu_exec_comb: combinational ALU result (incl. *W forms) and branch compare for one op
module alu_exec_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] opr1,
  input  logic [XLEN-1:0] opr2,
  input  logic            half,
  input  logic [2:0]      alu_func,
  input  logic            func_mod,
  input  logic [XLEN-1:0] cmp_a,
  input  logic [XLEN-1:0] cmp_b,
  input  logic [2:0]      cmp_func,
  output logic [XLEN-1:0] result,
  output logic            cmp_result
);
  localparam int SW = XLEN == 64 ? 6 : 5;
  logic hw, lt, q, w_ok;
  logic [SW-1:0] shamt;
  logic [XLEN-1:0] lo_s, lo_u, sh_in, r;
  logic signed [XLEN-1:0] sra, rw;
  always_comb begin
    hw = XLEN == 64 && half;
    shamt = opr2[SW-1:0] & (hw ? SW'(31) : '1);
    lo_s = XLEN'($signed(opr1[31:0]));
    lo_u = XLEN'(opr1[31:0]);
    sh_in = hw ? (func_mod ? lo_s : lo_u) : opr1;
    sra = $signed(sh_in) >>> shamt;
    r = alu_func == ALU_ADD_SUB ? (func_mod ? opr1 - opr2 : opr1 + opr2) :
        alu_func == ALU_SLL ? opr1 << shamt :
        alu_func == ALU_SLT ? XLEN'($signed(opr1) < $signed(opr2)) :
        alu_func == ALU_SLTU ? XLEN'(opr1 < opr2) :
        alu_func == ALU_XOR ? opr1 ^ opr2 :
        alu_func == ALU_SRL_SRA ? (func_mod ? sra : sh_in >> shamt) :
        alu_func == ALU_OR ? opr1 | opr2 :
        (func_mod ? ~opr1 : opr1) & opr2;
    rw = XLEN'($signed(r[31:0]));
    w_ok = alu_func == ALU_ADD_SUB || alu_func == ALU_SLL || alu_func == ALU_SRL_SRA;
    result = !hw ? r : w_ok ? rw : '0;
    lt = cmp_func[CMP_UNSIGNED] ? cmp_a < cmp_b : $signed(cmp_a) < $signed(cmp_b);
    q = cmp_func[CMP_LESS] ? lt : cmp_a == cmp_b;
    cmp_result = q ^ cmp_func[CMP_NEGATE];
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU/compare unit with valid/ready back-pressure, flush and WFI drain
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int STAGES = 2,
  parameter int ROB_INDEX_WIDTH = 6,
  parameter int PHY_REG_ADDR_WIDTH = 6,
  parameter int VIRTUAL_ADDR_LEN = 39
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          wfi_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [XLEN-1:0]               opr1_i,
  input  logic [XLEN-1:0]               opr2_i,
  input  logic                          half_i,
  input  logic [2:0]                    alu_func_i,
  input  logic                          func_mod_i,
  input  logic [XLEN-1:0]               cmp_a_i,
  input  logic [XLEN-1:0]               cmp_b_i,
  input  logic [2:0]                    cmp_func_i,
  input  logic                          is_jump_i,
  input  logic                          is_branch_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]   pc_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]   next_pc_i,
  input  logic [ROB_INDEX_WIDTH-1:0]    rob_index_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr_i,
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
  output logic [XLEN-1:0]               alu_result_o,
  output logic                          cmp_result_o,
  output logic                          is_jump_o,
  output logic                          is_branch_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]   pc_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]   next_pc_o,
  output logic [ROB_INDEX_WIDTH-1:0]    rob_index_o,
  output logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr_o,
  output logic                          busy_o
);
  if ((XLEN != 32 && XLEN != 64) || STAGES < 1 || STAGES > 3 || VIRTUAL_ADDR_LEN > UOP_VA ||
      ROB_INDEX_WIDTH > UOP_ROB || PHY_REG_ADDR_WIDTH > UOP_PRD) begin : g_bad
    $error("alu_pipe: unsupported parameter set");
  end
  logic stall, en, acc, cmp;
  logic [XLEN-1:0] res;
  logic [STAGES-1:0] vld;
  alu_uop_t uop_n, uop_o;
  alu_exec_comb #(.XLEN(XLEN)) u_exec (
    .opr1(opr1_i),
    .opr2(opr2_i),
    .half(half_i),
    .alu_func(alu_func_i),
    .func_mod(func_mod_i),
    .cmp_a(cmp_a_i),
    .cmp_b(cmp_b_i),
    .cmp_func(cmp_func_i),
    .result(res),
    .cmp_result(cmp)
  );
  always_comb begin
    stall = resp_valid_o & ~resp_ready_i;
    en = ~stall;
    req_ready_o = ~wfi_i & ~stall;
    acc = req_valid_i & req_ready_o & ~flush_i;
    uop_n = '{result: UOP_XLEN'(res), cmp: cmp, is_jump: is_jump_i, is_branch: is_branch_i,
              pc: UOP_VA'(pc_i), next_pc: UOP_VA'(next_pc_i), rob: UOP_ROB'(rob_index_i),
              prd: UOP_PRD'(prd_addr_i)};
  end
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic v, v_d;
    alu_uop_t u, u_d;
    if (i == 0) begin : g_head
      assign v_d = acc;
      assign u_d = uop_n;
    end else begin : g_tail
      assign v_d = g_stage[i-1].v;
      assign u_d = g_stage[i-1].u;
    end
    always_ff @(posedge clk)
      if (rst) begin
        v <= 1'b0;
        u <= '0;
      end else begin
        v <= flush_i ? 1'b0 : en ? v_d : v;
        if (en) u <= u_d;
      end
    assign vld[i] = v;
  end
  assign uop_o = g_stage[STAGES-1].u;
  assign resp_valid_o = vld[STAGES-1];
  assign busy_o = |vld;
  assign alu_result_o = uop_o.result[XLEN-1:0];
  assign cmp_result_o = uop_o.cmp;
  assign is_jump_o = resp_valid_o & uop_o.is_jump;
  assign is_branch_o = resp_valid_o & uop_o.is_branch;
  assign pc_o = uop_o.pc[VIRTUAL_ADDR_LEN-1:0];
  assign next_pc_o = uop_o.next_pc[VIRTUAL_ADDR_LEN-1:0];
  assign rob_index_o = uop_o.rob[ROB_INDEX_WIDTH-1:0];
  assign prd_addr_o = uop_o.prd[PHY_REG_ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table plus stall/flush/wfi/reset sequences for alu_pipe
module tb_alu_pipe;
  import alu_pkg::*;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  logic clk = 1'b0;
  logic rst, flush_i, wfi_i, req_valid_i, req_ready_o, half_i, func_mod_i;
  logic [63:0] opr1_i, opr2_i, cmp_a_i, cmp_b_i, alu_result_o;
  logic [2:0] alu_func_i, cmp_func_i;
  logic is_jump_i, is_branch_i, resp_valid_o, resp_ready_i, cmp_result_o, is_jump_o, is_branch_o, busy_o;
  logic [38:0] pc_i, next_pc_i, pc_o, next_pc_o;
  logic [5:0] rob_index_i, prd_addr_i, rob_index_o, prd_addr_o;
  logic v32, r32_ready, r32_valid, r32_cmp, r32_j, r32_b, r32_busy;
  logic [31:0] a32, b32, r32_res;
  logic [38:0] r32_pc, r32_npc;
  logic [5:0] r32_rob, r32_prd;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  alu_pipe #(.XLEN(64), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .wfi_i(wfi_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .opr1_i(opr1_i), .opr2_i(opr2_i), .half_i(half_i), .alu_func_i(alu_func_i),
    .func_mod_i(func_mod_i), .cmp_a_i(cmp_a_i), .cmp_b_i(cmp_b_i), .cmp_func_i(cmp_func_i),
    .is_jump_i(is_jump_i), .is_branch_i(is_branch_i), .pc_i(pc_i), .next_pc_i(next_pc_i),
    .rob_index_i(rob_index_i), .prd_addr_i(prd_addr_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .alu_result_o(alu_result_o), .cmp_result_o(cmp_result_o),
    .is_jump_o(is_jump_o), .is_branch_o(is_branch_o), .pc_o(pc_o), .next_pc_o(next_pc_o),
    .rob_index_o(rob_index_o), .prd_addr_o(prd_addr_o), .busy_o(busy_o)
  );
  alu_pipe #(.XLEN(32), .STAGES(1)) dut32 (
    .clk(clk), .rst(rst), .flush_i(1'b0), .wfi_i(1'b0),
    .req_valid_i(v32), .req_ready_o(r32_ready),
    .opr1_i(a32), .opr2_i(b32), .half_i(1'b1), .alu_func_i(ALU_SLL),
    .func_mod_i(1'b0), .cmp_a_i(a32), .cmp_b_i(b32), .cmp_func_i(3'b000),
    .is_jump_i(1'b0), .is_branch_i(1'b0), .pc_i(39'd0), .next_pc_i(39'd4),
    .rob_index_i(6'd0), .prd_addr_i(6'd0),
    .resp_valid_o(r32_valid), .resp_ready_i(1'b1),
    .alu_result_o(r32_res), .cmp_result_o(r32_cmp),
    .is_jump_o(r32_j), .is_branch_o(r32_b), .pc_o(r32_pc), .next_pc_o(r32_npc),
    .rob_index_o(r32_rob), .prd_addr_o(r32_prd), .busy_o(r32_busy)
  );
  typedef struct {
    logic [2:0] func;
    logic mod;
    logic half;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0] cf;
    logic [63:0] ca;
    logic [63:0] cb;
    logic [63:0] er;
    logic ec;
  } vec_t;
  vec_t v [17];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [2:0] f, input logic m, input logic h, input logic [63:0] a,
                       input logic [63:0] b, input logic [2:0] cf, input logic [63:0] ca,
                       input logic [63:0] cb, input int tag);
    alu_func_i = f;
    func_mod_i = m;
    half_i = h;
    opr1_i = a;
    opr2_i = b;
    cmp_func_i = cf;
    cmp_a_i = ca;
    cmp_b_i = cb;
    rob_index_i = 6'(tag);
    prd_addr_i = 6'(tag + 1);
    pc_i = 39'(4096 + 4 * tag);
    next_pc_i = 39'(4100 + 4 * tag);
    is_jump_i = tag[1];
    is_branch_i = tag[0];
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic lat0;
    int got, k;
    v[0]  = '{ALU_ADD_SUB, 1'b0, 1'b1, 64'h7FFF_FFFF, 64'd1, 3'b110, ONES, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0};
    v[1]  = '{ALU_ADD_SUB, 1'b1, 1'b0, 64'd5, 64'd7, 3'b101, 64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
    v[2]  = '{ALU_SRL_SRA, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 3'b101, ONES, 64'd1, ONES, 1'b0};
    v[3]  = '{ALU_SRL_SRA, 1'b1, 1'b1, 64'h8000_0000, 64'd31, 3'b000, 64'd3, 64'd3, ONES, 1'b1};
    v[4]  = '{ALU_SRL_SRA, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 3'b001, 64'd3, 64'd3, 64'd1, 1'b0};
    v[5]  = '{ALU_SLL, 1'b0, 1'b0, 64'd1, 64'h41, 3'b100, ONES, 64'd1, 64'd2, 1'b1};
    v[6]  = '{ALU_SLL, 1'b0, 1'b1, 64'd1, 64'd63, 3'b111, ONES, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b1};
    v[7]  = '{ALU_SLT, 1'b0, 1'b0, ONES, 64'd1, 3'b011, 64'd1, 64'd2, 64'd1, 1'b1};
    v[8]  = '{ALU_SLTU, 1'b0, 1'b0, ONES, 64'd1, 3'b010, 64'd7, 64'd7, 64'd0, 1'b1};
    v[9]  = '{ALU_XOR, 1'b0, 1'b0, 64'hFF00, 64'h0FF0, 3'b100, 64'd1, ONES, 64'hF0F0, 1'b0};
    v[10] = '{ALU_OR, 1'b0, 1'b0, 64'hFF00, 64'h0FF0, 3'b110, 64'd1, ONES, 64'hFFF0, 1'b1};
    v[11] = '{ALU_AND_CLR, 1'b0, 1'b0, 64'hFF00, 64'h0FF0, 3'b000, 64'd0, 64'd1, 64'h0F00, 1'b0};
    v[12] = '{ALU_AND_CLR, 1'b1, 1'b0, 64'hFF00, 64'h0FF0, 3'b101, 64'd1, ONES, 64'h00F0, 1'b1};
    v[13] = '{ALU_XOR, 1'b0, 1'b1, 64'hFF00, 64'h0FF0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1};
    v[14] = '{ALU_SRL_SRA, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 3'b100, 64'd0, 64'd0, 64'h0800_0000, 1'b0};
    v[15] = '{ALU_ADD_SUB, 1'b0, 1'b1, 64'hFFFF_FFFF, 64'd0, 3'b111, 64'd0, 64'd0, ONES, 1'b1};
    v[16] = '{ALU_SRL_SRA, 1'b1, 1'b0, 64'hF000_0000_0000_0000, 64'd4, 3'b001, 64'd1, 64'd2, 64'hFF00_0000_0000_0000, 1'b1};
    rst = 1'b1;
    flush_i = 1'b0;
    wfi_i = 1'b0;
    req_valid_i = 1'b0;
    resp_ready_i = 1'b1;
    v32 = 1'b0;
    a32 = '0;
    b32 = '0;
    drive(ALU_ADD_SUB, 1'b0, 1'b0, 64'd0, 64'd0, 3'b000, 64'd0, 64'd0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset resp_valid", 64'(resp_valid_o), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset tags", {62'd0, is_jump_o, is_branch_o}, 64'd0);
    check("reset result", alu_result_o, 64'd0);
    check("reset ready", 64'(req_ready_o), 64'd1);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(v[i].func, v[i].mod, v[i].half, v[i].a, v[i].b, v[i].cf, v[i].ca, v[i].cb, i);
      req_valid_i = 1'b1;
      @(negedge clk);
      req_valid_i = 1'b0;
      lat0 = resp_valid_o;
      @(negedge clk);
      check($sformatf("vec%0d latency", i), {62'd0, lat0, resp_valid_o}, 64'd1);
      check($sformatf("vec%0d result", i), alu_result_o, v[i].er);
      check($sformatf("vec%0d cmp", i), 64'(cmp_result_o), 64'(v[i].ec));
      check($sformatf("vec%0d tags", i), {rob_index_o, prd_addr_o, is_jump_o, is_branch_o},
            {6'(i), 6'(i + 1), 1'(i >> 1), 1'(i)});
      check($sformatf("vec%0d pc", i), {pc_o, 25'd0} ^ 64'(next_pc_o), {39'(4096 + 4 * i), 25'd0} ^ 64'(4100 + 4 * i));
    end
    @(negedge clk);
    v32 = 1'b1;
    a32 = 32'd1;
    b32 = 32'd33;
    @(negedge clk);
    v32 = 1'b0;
    check("xlen32 sll shamt33", {31'd0, r32_valid, r32_res}, {31'd1, 32'd2});
    got = 0;
    k = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      resp_ready_i = !(c >= 3 && c < 6);
      req_valid_i = k < 4;
      drive(ALU_ADD_SUB, 1'b0, 1'b0, 64'(k), 64'd100, 3'b000, 64'd0, 64'd0, 40 + k);
      #1;
      if (resp_valid_o) begin
        check($sformatf("stream c%0d rob", c), 64'(rob_index_o), 64'(40 + got));
        check($sformatf("stream c%0d result", c), alu_result_o, 64'(100 + got));
        if (!resp_ready_i) check($sformatf("stream c%0d stall ready", c), 64'(req_ready_o), 64'd0);
        if (resp_ready_i) got++;
      end
      if (req_valid_i && req_ready_o) k++;
    end
    check("stream delivered", 64'(got), 64'd4);
    req_valid_i = 1'b0;
    resp_ready_i = 1'b1;
    @(negedge clk);
    drive(ALU_OR, 1'b0, 1'b0, 64'd1, 64'd2, 3'b000, 64'd0, 64'd0, 1);
    req_valid_i = 1'b1;
    @(negedge clk);
    drive(ALU_OR, 1'b0, 1'b0, 64'd4, 64'd8, 3'b000, 64'd0, 64'd0, 2);
    @(negedge clk);
    drive(ALU_OR, 1'b0, 1'b0, 64'd16, 64'd32, 3'b000, 64'd0, 64'd0, 3);
    flush_i = 1'b1;
    wfi_i = 1'b1;
    #1;
    check("flush in-flight busy", 64'(busy_o), 64'd1);
    check("flush+wfi ready", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    flush_i = 1'b0;
    wfi_i = 1'b0;
    req_valid_i = 1'b0;
    check("flush busy cleared", 64'(busy_o), 64'd0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("flush no resp c%0d", c), 64'(resp_valid_o), 64'd0);
      @(negedge clk);
    end
    drive(ALU_XOR, 1'b0, 1'b0, 64'h5, 64'h3, 3'b000, 64'd0, 64'd0, 7);
    req_valid_i = 1'b1;
    @(negedge clk);
    wfi_i = 1'b1;
    #1;
    check("wfi ready", 64'(req_ready_o), 64'd0);
    check("wfi busy", 64'(busy_o), 64'd1);
    @(negedge clk);
    check("wfi drain", {62'd0, resp_valid_o, busy_o}, 64'd3);
    check("wfi drain result", alu_result_o, 64'h6);
    @(negedge clk);
    check("wfi idle", {62'd0, resp_valid_o, busy_o}, 64'd0);
    wfi_i = 1'b0;
    drive(ALU_ADD_SUB, 1'b0, 1'b0, 64'd9, 64'd9, 3'b000, 64'd0, 64'd0, 9);
    resp_ready_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    check("stall before rst", {62'd0, resp_valid_o, busy_o}, 64'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    resp_ready_i = 1'b1;
    check("rst mid-stall", {resp_valid_o, busy_o, is_jump_o, is_branch_o, 60'd0} | alu_result_o, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
